// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, the fetch
// queue entry layout and the NOP used for faulted entries.
package fetch_pkg;

    localparam int PC_W = 64;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetch entries with flush; pointers wrap naturally
// because DEPTH is a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       din,
    output logic [ENTRY_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]        count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one IMEM read per cycle
// while the fetch queue has room, and hands entries to decode.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN       = PC_W,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FQ_DEPTH   = 2,
    parameter int              IMEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_fault,
    output logic            fetch_halted
);

    localparam int CW = $clog2(FQ_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            infl_q, infl_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic            infl_epoch_q, infl_epoch_d;
    logic            infl_fault_q, infl_fault_d;

    logic [CW:0]     q_count;
    logic [CW:0]     occ;
    logic            deq, q_push, slot, oor;
    fetch_entry_t    q_din, q_dout;
    logic [ENTRY_W-1:0] q_din_w, q_dout_w;
    logic            unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    assign out_valid = (q_count != '0);
    assign deq       = out_valid & out_ready;
    // Occupancy once the current response lands and decode takes its entry.
    assign occ       = q_count + {{CW{1'b0}}, infl_q} - {{CW{1'b0}}, deq};
    assign oor       = pc_q[XLEN-1:2] >= (XLEN-2)'(IMEM_WORDS);
    assign slot      = (state_q == RUN) && !redirect_valid && (occ < (CW+1)'(FQ_DEPTH));
    assign imem_req  = slot && !oor;
    assign imem_addr = pc_q;
    assign q_push    = infl_q && (infl_epoch_q == epoch_q) && !redirect_valid;

    always_comb begin
        q_din.pc    = infl_pc_q;
        q_din.instr = infl_fault_q ? NOP_INSTR : imem_rdata;
        q_din.fault = infl_fault_q;
    end

    assign q_din_w = q_din;
    assign q_dout  = q_dout_w;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (deq),
        .flush (redirect_valid),
        .din   (q_din_w),
        .dout  (q_dout_w),
        .count (q_count)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        infl_d       = 1'b0;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = infl_epoch_q;
        infl_fault_d = infl_fault_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            epoch_d = ~epoch_q;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    // An out-of-range PC occupies a slot like a read, then halts.
                    if (slot) begin
                        infl_d       = 1'b1;
                        infl_pc_d    = pc_q;
                        infl_epoch_d = epoch_q;
                        infl_fault_d = oor;
                        if (oor) state_d = HALT;
                        else     pc_d    = pc_q + XLEN'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            infl_q  <= infl_d;
        end
    end

    always_ff @(posedge clk) begin
        infl_pc_q    <= infl_pc_d;
        infl_epoch_q <= infl_epoch_d;
        infl_fault_q <= infl_fault_d;
    end

    assign out_pc       = out_valid ? q_dout.pc    : '0;
    assign out_instr    = out_valid ? q_dout.instr : '0;
    assign out_fault    = out_valid ? q_dout.fault : 1'b0;
    assign fetch_halted = (state_q == HALT);

endmodule
